shift_seq8: RTL and testbench



---
 rtl/shift_seq8.sv | 126 ++++++++++++
 tb/tb_shift_seq8.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: splits a 0..7-bit LSL/LSR/ASR request into steps of at most MAX_STEP bits.
// Optional build macro SHIFT_SEQ8_ROR_EN turns op=00 into rotate-right instead of NOP.
module shift_seq8 #(
  parameter int unsigned MAX_STEP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  state_t     state, state_n;
  logic [7:0] work, work_n;
  logic [1:0] op_r, op_n;
  logic [2:0] rem, rem_n;
  logic [7:0] dout_n;

  logic [1:0] step;
  logic [2:0] rem_left;
  logic [7:0] shifted;
  logic       passthru;

  // Single-cycle shift stage with a 2-bit shift amount.
  function automatic logic [7:0] shift_stage(input logic [7:0] v,
                                             input logic [1:0] o,
                                             input logic [1:0] amt);
    logic [7:0] r;
    r = v;
    case (o)
      OP_LSL:  r = v << amt;
      OP_LSR:  r = v >> amt;
      OP_ASR:  r = $signed(v) >>> amt;
`ifdef SHIFT_SEQ8_ROR_EN
      default: r = 8'({v, v} >> amt);
`else
      default: r = v;
`endif
    endcase
    return r;
  endfunction

  always_comb begin
`ifdef SHIFT_SEQ8_ROR_EN
    passthru = (shamt == 3'd0);
`else
    passthru = (shamt == 3'd0) || (op == OP_NOP);
`endif
  end

  always_comb begin
    step     = (rem > 3'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
    rem_left = rem - {1'b0, step};
    shifted  = shift_stage(work, op_r, step);
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    op_n    = op_r;
    rem_n   = rem;
    dout_n  = d_out;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          work_n = d_in;
          op_n   = op;
          rem_n  = shamt;
          if (passthru) begin
            state_n = DONE;
            dout_n  = d_in;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = shifted;
        rem_n  = rem_left;
        if (rem_left == 3'd0) begin
          state_n = DONE;
          dout_n  = shifted;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      op_r  <= '0;
      rem   <= '0;
      d_out <= '0;
    end else begin
      state <= state_n;
      work  <= work_n;
      op_r  <= op_n;
      rem   <= rem_n;
      d_out <= dout_n;
    end
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: per-cycle comparison against a whole-shift model plus directed literal cases.
module tb_shift_seq8;
  localparam int unsigned MS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] shamt = 3'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  shift_seq8 #(.MAX_STEP(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .d_in(d_in), .d_out(d_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state: remaining busy cycles, pending whole-shift result, visible outputs.
  int         m_cnt = 0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] m_res = 8'h00;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] o, input int s);
    logic [7:0] r;
    r = d;
    case (o)
      2'b01: r = d << s;
      2'b10: r = d >> s;
      2'b11: r = $signed(d) >>> s;
      default: begin
`ifdef SHIFT_SEQ8_ROR_EN
        for (int i = 0; i < s; i++) r = {r[0], r[7:1]};
`else
        r = d;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic bit ref_pass(input logic [1:0] o, input int s);
`ifdef SHIFT_SEQ8_ROR_EN
    return (s == 0);
`else
    return (s == 0) || (o == 2'b00);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_busy = 0; m_done = 0; m_dout = 8'h00;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 0; m_done = 1; m_dout = m_res;
      end
    end else begin
      m_done = 0;
      if (start) begin
        if (ref_pass(op, int'(shamt))) begin
          m_done = 1; m_dout = d_in;
        end else begin
          m_busy = 1;
          m_cnt  = (int'(shamt) + MS - 1) / MS;
          m_res  = ref_shift(d_in, op, int'(shamt));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_dout", d_out, m_dout);
    end
  end

  task automatic req(input string name, input logic [7:0] d, input logic [1:0] o,
                     input logic [2:0] s, input logic [7:0] exp_d, input int exp_busy);
    int lat;
    int nb;
    start = 1'b1; d_in = d; op = o; shamt = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nb = 0;
    while (!done && lat < 16) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    check({name, "_busycyc"}, nb, exp_busy);
    check({name, "_lat"}, lat, exp_busy + 1);
    check({name, "_dout"}, d_out, exp_d);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", d_out, 8'h00);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    req("asr7", 8'b1010_0001, 2'b11, 3'd7, 8'b1111_1111, 3);
    req("lsr5", 8'b0110_0001, 2'b10, 3'd5, 8'b0000_0011, 2);
    req("lsl3", 8'b0110_0001, 2'b01, 3'd3, 8'b0000_1000, 1);
    req("sh0",  8'b0110_0001, 2'b11, 3'd0, 8'b0110_0001, 0);
    req("lsl7", 8'hFF, 2'b01, 3'd7, 8'h80, 3);
    req("asr6", 8'h7F, 2'b11, 3'd6, 8'h01, 2);
    req("lsr1", 8'h80, 2'b10, 3'd1, 8'h40, 1);
    req("asr2", 8'h80, 2'b11, 3'd2, 8'hE0, 1);
`ifdef SHIFT_SEQ8_ROR_EN
    req("ror4", 8'b1010_0001, 2'b00, 3'd4, 8'b0001_1010, 2);
    req("ror7", 8'b1010_0001, 2'b00, 3'd7, 8'b0100_0011, 3);
    req("ror0", 8'b0110_0001, 2'b00, 3'd0, 8'b0110_0001, 0);
`else
    req("nop5", 8'b0110_0001, 2'b00, 3'd5, 8'b0110_0001, 0);
    req("nop0", 8'b0110_0001, 2'b00, 3'd0, 8'b0110_0001, 0);
`endif

    // start pulse during SHIFT must not disturb the running request
    start = 1'b1; d_in = 8'b1010_0001; op = 2'b11; shamt = 3'd7;
    @(negedge clk);
    d_in = 8'hFF; op = 2'b01; shamt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 1);
    @(negedge clk);
    check("ign_done", done, 1);
    check("ign_dout", d_out, 8'hFF);
    @(negedge clk);
    check("ign_idle", done, 0);

    // start held through DONE: second request accepted with no IDLE cycle
    start = 1'b1; d_in = 8'b0110_0001; op = 2'b10; shamt = 3'd5;
    @(negedge clk);
    d_in = 8'b1010_0001; op = 2'b11; shamt = 3'd2;
    @(negedge clk);
    check("b2b_busy1", busy, 1);
    @(negedge clk);
    check("b2b_done1", done, 1);
    check("b2b_dout1", d_out, 8'b0000_0011);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy2", busy, 1);
    check("b2b_nodone", done, 0);
    @(negedge clk);
    check("b2b_done2", done, 1);
    check("b2b_dout2", d_out, 8'b1110_1000);
    @(negedge clk);

    // reset in the 2nd SHIFT cycle aborts the operation
    start = 1'b1; d_in = 8'b1010_0001; op = 2'b11; shamt = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_dout", d_out, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst2_nodone", done, 0);
    end

    // reset and start together: reset wins
    reset = 1'b1; start = 1'b1; d_in = 8'h55; op = 2'b01; shamt = 3'd0;
    @(negedge clk);
    check("rst_start_done", done, 0);
    check("rst_start_dout", d_out, 8'h00);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
